// File: rtl/bram_stream_reader.sv
// Streams a burst of words out of a 2-cycle-latency block RAM through a small output FIFO.
// Optional BRAM_RD_STALL_CNT_EN adds a saturating stall_cnt_o counter of valid-but-not-ready cycles.
//
// state | meaning
// IDLE  | waiting for start_i; len_i==0 completes immediately with done_o
// ISSUE | issuing RAM reads while FIFO space allows
// DRAIN | all reads issued; waiting for the last word to be accepted
module bram_stream_reader #(
  parameter int RAM_WIDTH  = 32,
  parameter int ADDR_LINES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [ADDR_LINES-1:0] base_addr_i,
  input  logic [ADDR_LINES:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ram_en_o,
  output logic [ADDR_LINES-1:0] ram_addr_o,
  output logic                  ram_regce_o,
  input  logic [RAM_WIDTH-1:0]  ram_dout_i,
  output logic [RAM_WIDTH-1:0]  m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o
`ifdef BRAM_RD_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt_o
`endif
);

  localparam int AW = ADDR_LINES;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] FIFO_LIM = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state_q, state_d;
  logic                done_d, done_q;
  logic [AW:0]         len_q, cnt_q;
  logic [AW-1:0]       base_q;
  logic                rd_p1, rd_p2, last_p1, last_p2;
  logic [RAM_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic                fifo_last [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic [CW:0]         pending;
  logic                issue, issue_last, push, pop, start_ok;

  // Reads in the RAM pipeline count against FIFO space so a push never finds it full.
  assign pending    = {1'b0, count} + (CW+1)'(rd_p1) + (CW+1)'(rd_p2);
  assign issue      = (state_q == ISSUE) && (cnt_q != len_q) && (pending < FIFO_LIM);
  assign issue_last = issue && ((cnt_q + (AW+1)'(1)) == len_q);
  assign push       = rd_p2;
  assign pop        = m_valid_o && m_ready_i;
  assign start_ok   = (state_q == IDLE) && start_i;

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign ram_en_o    = issue;
  assign ram_addr_o  = issue ? (base_q + cnt_q[AW-1:0]) : '0;
  assign ram_regce_o = rd_p1;
  assign m_valid_o   = (count != '0);
  assign m_data_o    = m_valid_o ? fifo_data[rd_ptr] : '0;
  assign m_last_o    = m_valid_o && fifo_last[rd_ptr];

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) state_d = ISSUE;
          else             done_d  = 1'b1;
        end
      end
      ISSUE: if (issue_last) state_d = DRAIN;
      DRAIN: begin
        if (pop && m_last_o) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      len_q   <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      rd_p1   <= 1'b0;
      rd_p2   <= 1'b0;
      last_p1 <= 1'b0;
      last_p2 <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (start_ok) begin
        len_q  <= len_i;
        base_q <= base_addr_i;
        cnt_q  <= '0;
      end else if (issue) begin
        cnt_q <= cnt_q + (AW+1)'(1);
      end
      rd_p1   <= issue;
      rd_p2   <= rd_p1;
      last_p1 <= issue_last;
      last_p2 <= last_p1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr] <= ram_dout_i;
      fifo_last[wr_ptr] <= last_p2;
    end
  end

`ifdef BRAM_RD_STALL_CNT_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                                            stall_cnt_o <= '0;
    else if (start_ok)                                      stall_cnt_o <= '0;
    else if (m_valid_o && !m_ready_i && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a 2-cycle-latency RAM model (RAM[i] = 0x100+i).
// Define BRAM_RD_STALL_CNT_EN to also exercise stall_cnt_o.
module tb_bram_stream_reader;
  localparam int RW = 32;
  localparam int AL = 4;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rstn_i;
  logic          start_i;
  logic [AL-1:0] base_addr_i;
  logic [AL:0]   len_i;
  logic          busy_o, done_o, ram_en_o, ram_regce_o;
  logic [AL-1:0] ram_addr_o;
  logic [RW-1:0] ram_dout_i;
  logic [RW-1:0] m_data_o;
  logic          m_valid_o, m_ready_i, m_last_o;
`ifdef BRAM_RD_STALL_CNT_EN
  logic [15:0]   stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_stream_reader #(.RAM_WIDTH(RW), .ADDR_LINES(AL), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .ram_en_o(ram_en_o),
    .ram_addr_o(ram_addr_o), .ram_regce_o(ram_regce_o), .ram_dout_i(ram_dout_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_last_o(m_last_o)
`ifdef BRAM_RD_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  // RAM model: address latched on ena, output register loaded on regcea.
  logic [RW-1:0] ram_q1 = '0;
  initial ram_dout_i = '0;
  always @(posedge clk) begin
    if (ram_en_o) ram_q1 <= RW'(32'h100 + 32'(ram_addr_o));
    if (ram_regce_o) ram_dout_i <= ram_q1;
  end

  logic [RW-1:0] got_data[$];
  bit            got_last[$];
  int            got_cyc[$];
  int            addr_q[$];
  int            done_cyc, en_cnt, regce_err, stab_err, max_out;
  bit            busy_seen, timed_out;

  // Runs one burst starting at the current negedge; returns at the negedge where done_o is seen.
  task automatic run_burst(input int base, input int len, input int stall_n, input int budget);
    int stall_left = 0;
    bit stall_used = 0;
    int acc = 0;
    bit pv = 0;
    logic [RW-1:0] pd = '0;
    logic pl = 0;
    logic prev_en = 0;
    got_data.delete(); got_last.delete(); got_cyc.delete(); addr_q.delete();
    done_cyc = -1; en_cnt = 0; regce_err = 0; stab_err = 0; max_out = 0;
    busy_seen = 0; timed_out = 0;
    start_i = 1'b1; base_addr_i = AL'(base); len_i = (AL+1)'(len); m_ready_i = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); @(negedge clk);
      start_i = 1'b0;
      if (!stall_used && m_valid_o && stall_n > 0) begin
        stall_used = 1; stall_left = stall_n;
      end
      m_ready_i = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (ram_regce_o !== prev_en) regce_err++;
      prev_en = ram_en_o;
      if (ram_en_o) begin addr_q.push_back(int'(ram_addr_o)); en_cnt++; end
      if (busy_o) busy_seen = 1;
      if (pv && !(m_valid_o && m_data_o === pd && m_last_o === pl)) stab_err++;
      if (en_cnt - acc > max_out) max_out = en_cnt - acc;
      if (m_valid_o && m_ready_i) begin
        got_data.push_back(m_data_o); got_last.push_back(m_last_o); got_cyc.push_back(c); acc++;
      end
      pv = m_valid_o && !m_ready_i; pd = m_data_o; pl = m_last_o;
      if (done_o) begin done_cyc = c; return; end
    end
    timed_out = 1;
  endtask

  task automatic idle(input int n);
    start_i = 1'b0; m_ready_i = 1'b1;
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic test_reset;
    rstn_i = 1'b0; start_i = 1'b0; base_addr_i = '0; len_i = '0; m_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_o, done_o, ram_en_o, ram_regce_o, m_valid_o, m_last_o} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000",
        {busy_o, done_o, ram_en_o, ram_regce_o, m_valid_o, m_last_o});
    end
    checks++;
    if (ram_addr_o !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", ram_addr_o); end
    checks++;
    if (m_data_o !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", m_data_o); end
`ifdef BRAM_RD_STALL_CNT_EN
    checks++;
    if (stall_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt_o); end
`endif
    rstn_i = 1'b1;
    idle(2);
  endtask

  task automatic test_basic;
    idle(2);
    run_burst(2, 5, 0, 100);
    checks++;
    if (timed_out) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
    checks++;
    if (got_data.size() != 5) begin errors++; $display("FAIL basic_count: got %0d expected 5", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 5; i++) begin
      checks++;
      if (got_data[i] !== RW'(32'h102 + i) || got_last[i] !== (i == 4)) begin
        errors++; $display("FAIL basic_word[%0d]: got %h/%0b expected %h/%0b", i, got_data[i], got_last[i], 32'h102 + i, i == 4);
      end
      checks++;
      if (got_cyc[i] != got_cyc[0] + i) begin
        errors++; $display("FAIL basic_cycle[%0d]: got %0d expected %0d", i, got_cyc[i], got_cyc[0] + i);
      end
    end
    if (got_cyc.size() == 5) begin
      checks++;
      if (got_cyc[0] < 3) begin errors++; $display("FAIL basic_latency: got %0d expected >=3", got_cyc[0]); end
      checks++;
      if (done_cyc != got_cyc[4] + 1) begin errors++; $display("FAIL basic_done: got %0d expected %0d", done_cyc, got_cyc[4] + 1); end
    end
    checks++;
    if (en_cnt != 5 || regce_err != 0) begin
      errors++; $display("FAIL basic_reads: got en=%0d regce_err=%0d expected 5/0", en_cnt, regce_err);
    end
    idle(1);
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL basic_after: got done=%b busy=%b expected 0/0", done_o, busy_o);
    end
  endtask

  task automatic test_wrap;
    int exp_addr[4] = '{14, 15, 0, 1};
    idle(2);
    run_burst(14, 4, 0, 100);
    checks++;
    if (timed_out || addr_q.size() != 4 || got_data.size() != 4) begin
      errors++; $display("FAIL wrap_count: got addr=%0d words=%0d expected 4/4", addr_q.size(), got_data.size());
    end
    for (int i = 0; i < 4 && i < addr_q.size() && i < got_data.size(); i++) begin
      checks++;
      if (addr_q[i] != exp_addr[i] || got_data[i] !== RW'(32'h100 + exp_addr[i])) begin
        errors++; $display("FAIL wrap[%0d]: got addr %0d data %h expected addr %0d data %h",
          i, addr_q[i], got_data[i], exp_addr[i], 32'h100 + exp_addr[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    idle(2);
    run_burst(0, 16, 10, 300);
    checks++;
    if (timed_out || got_data.size() != 16) begin
      errors++; $display("FAIL bp_count: got %0d words expected 16", got_data.size());
    end
    for (int i = 0; i < 16 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== RW'(32'h100 + i) || got_last[i] !== (i == 15)) begin
        errors++; $display("FAIL bp_word[%0d]: got %h/%0b expected %h/%0b", i, got_data[i], got_last[i], 32'h100 + i, i == 15);
      end
    end
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", stab_err); end
    checks++;
    if (max_out > FD) begin errors++; $display("FAIL bp_outstanding: got %0d expected <=%0d", max_out, FD); end
`ifdef BRAM_RD_STALL_CNT_EN
    checks++;
    if (stall_cnt_o !== 16'd10) begin errors++; $display("FAIL bp_stall_cnt: got %0d expected 10", stall_cnt_o); end
`endif
  endtask

  task automatic test_zero_len;
    idle(2);
    run_burst(3, 0, 0, 20);
    checks++;
    if (done_cyc != 1) begin errors++; $display("FAIL zero_done: got cycle %0d expected 1", done_cyc); end
    checks++;
    if (en_cnt != 0 || busy_seen || got_data.size() != 0) begin
      errors++; $display("FAIL zero_activity: got en=%0d busy=%0b words=%0d expected 0/0/0", en_cnt, busy_seen, got_data.size());
    end
    idle(1);
    checks++;
    if (done_o !== 1'b0) begin errors++; $display("FAIL zero_pulse: got %b expected 0", done_o); end
  endtask

  task automatic test_back_to_back;
    idle(2);
    run_burst(0, 3, 0, 100);
    checks++;
    if (timed_out || got_data.size() != 3) begin errors++; $display("FAIL b2b_first: got %0d words expected 3", got_data.size()); end
    run_burst(5, 2, 0, 100);
    checks++;
    if (timed_out || got_data.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d words expected 2", got_data.size());
    end else begin
      checks++;
      if (got_data[0] !== RW'(32'h105) || got_data[1] !== RW'(32'h106) || got_last[1] !== 1'b1) begin
        errors++; $display("FAIL b2b_data: got %h %h expected 105 106", got_data[0], got_data[1]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int acc = 0;
    idle(2);
    start_i = 1'b1; base_addr_i = '0; len_i = (AL+1)'(8); m_ready_i = 1'b1;
    for (int c = 0; c < 50 && acc < 3; c++) begin
      @(posedge clk); @(negedge clk);
      start_i = 1'b0;
      if (m_valid_o && m_ready_i) acc++;
    end
    checks++;
    if (acc != 3) begin errors++; $display("FAIL mid_progress: got %0d words expected 3", acc); end
    @(posedge clk); #2;
    rstn_i = 1'b0; #1;
    checks++;
    if ({busy_o, done_o, ram_en_o, ram_regce_o, m_valid_o, m_last_o} !== 6'b0 || ram_addr_o !== '0 || m_data_o !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: got ctrl %b addr %h data %h expected all 0",
        {busy_o, done_o, ram_en_o, ram_regce_o, m_valid_o, m_last_o}, ram_addr_o, m_data_o);
    end
    @(negedge clk); rstn_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || m_valid_o !== 1'b0) begin
        errors++; $display("FAIL mid_quiet[%0d]: got done=%b busy=%b valid=%b expected 0", c, done_o, busy_o, m_valid_o);
      end
    end
    run_burst(0, 2, 0, 100);
    checks++;
    if (timed_out || got_data.size() != 2) begin
      errors++; $display("FAIL mid_restart_count: got %0d words expected 2", got_data.size());
    end else begin
      checks++;
      if (got_data[0] !== RW'(32'h100) || got_data[1] !== RW'(32'h101)) begin
        errors++; $display("FAIL mid_restart_data: got %h %h expected 100 101", got_data[0], got_data[1]);
      end
    end
  endtask

`ifdef BRAM_RD_STALL_CNT_EN
  task automatic test_stall_cnt;
    idle(2);
    run_burst(4, 16, 7, 300);
    checks++;
    if (timed_out || got_data.size() != 16) begin errors++; $display("FAIL stall_burst: got %0d words expected 16", got_data.size()); end
    checks++;
    if (stall_cnt_o !== 16'd7) begin errors++; $display("FAIL stall_cnt: got %0d expected 7", stall_cnt_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_back_to_back();
    test_reset_mid();
`ifdef BRAM_RD_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 32, meaning data width; it matches the dual_port_ram data width.
REQ-002 SHALL have parameter ADDR_LINES, default 4, meaning RAM address bits; RAM_DEPTH = 1<<ADDR_LINES.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning output buffer entries; power of 2, at least 4.
REQ-004 SHALL use one clock; reset is asynchronous and active-low; ports clk_i and rstn_i.
REQ-005 SHALL have port clk_i, input, 1, rising-edge clock.
REQ-006 SHALL have port rstn_i, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start_i, input, 1, one-cycle request to begin a burst.
REQ-008 SHALL have port base_addr_i, input, ADDR_LINES, first RAM address.
REQ-009 SHALL have port len_i, input, ADDR_LINES+1, word count, 0..RAM_DEPTH.
REQ-010 SHALL have port busy_o, output, 1, high while a burst is in progress.
REQ-011 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port ram_en_o, output, 1, drives RAM port-A ena; RAM wea is tied low at integration.
REQ-013 SHALL have port ram_addr_o, output, ADDR_LINES, drives addra.
REQ-014 SHALL have port ram_regce_o, output, 1, drives regcea.
REQ-015 SHALL have port ram_dout_i, input, RAM_WIDTH, from douta.
REQ-016 SHALL have port m_data_o, output, RAM_WIDTH, stream data.
REQ-017 SHALL have port m_valid_o, output, 1, stream valid.
REQ-018 SHALL have port m_ready_i, input, 1, stream ready.
REQ-019 SHALL have port m_last_o, output, 1, marks the final word of a burst.

Function
REQ-020 SHALL implement the states IDLE, ISSUE and DRAIN.
- IDLE -> ISSUE on start_i with len_i>0.
- ISSUE -> DRAIN after the len-th read is issued.
- DRAIN -> IDLE when the last word is accepted (m_valid_o & m_ready_i & m_last_o).
REQ-021 SHALL, on start_i with len_i==0 in IDLE, stay in IDLE and pulse done_o the next cycle.
REQ-022 SHALL ignore start_i when busy_o is high; busy_o is high in ISSUE and DRAIN.
REQ-023 SHALL issue a read by asserting ram_en_o for one cycle with ram_addr_o = base + issued count, modulo RAM_DEPTH (wrap-around, no error).
REQ-024 SHALL assert ram_regce_o exactly in the cycle after each issued read; the RAM word is valid on ram_dout_i two cycles after issue.
REQ-025 SHALL push ram_dout_i into the FIFO in the cycle it becomes valid; each entry carries a last flag set for the len-th word.
REQ-026 SHALL issue a read only when FIFO occupancy plus in-flight reads (0..2) is less than FIFO_DEPTH; the FIFO therefore never overflows.
REQ-027 SHALL sustain one word per cycle when m_ready_i is held high; first m_valid_o no earlier than 3 cycles after start_i.
REQ-028 SHALL follow the stream handshake:
- m_data_o, m_last_o and m_valid_o remain stable while m_valid_o is high and m_ready_i is low.
- m_valid_o never depends combinationally on m_ready_i.
REQ-029 SHALL handle a simultaneous FIFO push and pop in one cycle with occupancy unchanged.
REQ-030 SHALL assert done_o in the cycle after the last word is accepted; a start_i in that done cycle is accepted.

Reset
REQ-031 SHALL, on rstn_i low, immediately return to IDLE, flush the FIFO and in-flight tracking, and drive:
- busy_o, done_o, ram_en_o, ram_regce_o, m_valid_o, m_last_o = 0
- ram_addr_o, m_data_o = 0
REQ-032 SHALL, on reset asserted mid-burst, discard the burst with no done_o; operation resumes on the first start_i after release.

Configuration
REQ-033 SHALL, with macro BRAM_RD_STALL_CNT_EN defined, add output stall_cnt_o, 16 bits.
- Cleared on reset and on each accepted start.
- Increments each cycle m_valid_o & ~m_ready_i; saturates at 0xFFFF.
REQ-034 SHALL, without BRAM_RD_STALL_CNT_EN, omit the stall_cnt_o port and its logic entirely.

Verification
REQ-035 SHALL cover: RAM[i]=0x100+i; start base=2, len=5, m_ready=1 -> words 0x102..0x106 on consecutive cycles, m_last on 0x106, done_o one cycle later.
REQ-036 SHALL cover: base=14, len=4 (ADDR_LINES=4) -> addresses 14,15,0,1; data 0x10E,0x10F,0x100,0x101.
REQ-037 SHALL cover: len=16, m_ready low for 10 cycles after first valid -> at most 4 words buffered, no loss or duplication, data held stable, all 16 delivered in order.
REQ-038 SHALL cover: start with len=0 -> no ram_en_o, done_o pulse 1 cycle later, busy_o stays 0.
REQ-039 SHALL cover: rstn_i low after 3 words of len=8 -> all outputs 0 immediately; new start base=0, len=2 -> 0x100, 0x101 only.
REQ-040 SHALL cover (with BRAM_RD_STALL_CNT_EN): 7 stalled cycles during a burst -> stall_cnt_o = 7.
